// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer: drives the select and active-low enable of a 4-to-16 decoder.
// Walks the indices not masked off, holding each one for a programmable dwell time.
// Inserts BLANK_CYCLES of blanking before each step, and runs single-pass or continuous.
// Optional feature: define SCAN_FRAME_CNT_EN to add the 8-bit frame_cnt output.
module decoder_scan_sequencer #(
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               mode_cont,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [15:0]        skip_mask,
    output logic [3:0]         dec_in,
    output logic               dec_enable,
    output logic               step_strobe,
    output logic               busy,
    output logic               done
`ifdef SCAN_FRAME_CNT_EN
    ,output logic [7:0]        frame_cnt
`endif
);

    localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
    localparam int CNT_W   = (DWELL_W > BLANK_W) ? DWELL_W : BLANK_W;

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [3:0]         dec_in_nxt;
    logic               done_nxt;
    logic               latch;
    logic               cont_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [15:0]        mask_q;

    logic               first_any;
    logic [3:0]         first_idx;
    logic [3:0]         lo_idx;
    logic               up_any;
    logic [3:0]         up_idx;

    // Index search: the lowest live-unmasked index (used at start), the lowest latched-unmasked
    // index (used for the wrap), and the next latched-unmasked index above the current select.
    always_comb begin
        first_any = 1'b0;
        first_idx = 4'd0;
        lo_idx    = 4'd0;
        up_any    = 1'b0;
        up_idx    = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (!skip_mask[i]) begin
                first_any = 1'b1;
                first_idx = 4'(i);
            end
            if (!mask_q[i]) begin
                lo_idx = 4'(i);
                if (i > int'(dec_in)) begin
                    up_any = 1'b1;
                    up_idx = 4'(i);
                end
            end
        end
    end

    // Next-state logic; cnt counts up from 0 inside each BLANK or DRIVE phase.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        dec_in_nxt = dec_in;
        done_nxt   = 1'b0;
        latch      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    latch   = 1'b1;
                    cnt_nxt = '0;
                    if (first_any) begin
                        state_nxt  = BLANK;
                        dec_in_nxt = first_idx;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            BLANK: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_W'(BLANK_CYCLES - 1)) begin
                    state_nxt = DRIVE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            DRIVE: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_W'(dwell_q)) begin
                    cnt_nxt = '0;
                    if (up_any) begin
                        state_nxt  = BLANK;
                        dec_in_nxt = up_idx;
                    end else if (cont_q) begin
                        state_nxt  = BLANK;
                        dec_in_nxt = lo_idx;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register, plus the scan configuration captured when a start is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            dec_in  <= 4'd0;
            done    <= 1'b0;
            cont_q  <= 1'b0;
            dwell_q <= '0;
            mask_q  <= '1;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            dec_in <= dec_in_nxt;
            done   <= done_nxt;
            if (latch) begin
                cont_q  <= mode_cont;
                dwell_q <= dwell;
                mask_q  <= skip_mask;
            end
        end
    end

    // The outputs decode the registered state only, so an async reset clears them at once.
    assign dec_enable  = (state != DRIVE);
    assign busy        = (state != IDLE);
    assign step_strobe = (state == DRIVE) && (cnt == '0);

`ifdef SCAN_FRAME_CNT_EN
    logic pass_end;
    assign pass_end = (state == DRIVE) && !stop && (cnt == CNT_W'(dwell_q)) && !up_any;

    // Counts passes past the highest unmasked index; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        frame_cnt <= 8'd0;
        else if (pass_end) frame_cnt <= frame_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb_decoder_scan_sequencer: random and directed scans checked against a per-cycle model.
// The model derives each cycle's outputs arithmetically from the step period and the list of
// unmasked indices.
module tb_decoder_scan_sequencer;
    localparam int DW = 8;
    localparam int BC = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, stop = 1'b0, mode_cont = 1'b0;
    logic [DW-1:0] dwell = '0;
    logic [15:0]   skip_mask = '0;
    logic [3:0]    dec_in;
    logic          dec_enable, step_strobe, busy, done;
    int            checks = 0, failures = 0;
    int            fc_base = 0;
`ifdef SCAN_FRAME_CNT_EN
    logic [7:0]    frame_cnt;
`endif

    always #5 clk = ~clk;

    decoder_scan_sequencer #(.DWELL_W(DW), .BLANK_CYCLES(BC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode_cont(mode_cont),
        .dwell(dwell), .skip_mask(skip_mask), .dec_in(dec_in), .dec_enable(dec_enable),
        .step_strobe(step_strobe), .busy(busy), .done(done)
`ifdef SCAN_FRAME_CNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    typedef struct {
        int idx;
        bit idx_valid, en, strobe, busy, done;
        int frames;
    } exp_t;

    // Expected outputs in cycle k after the start edge (k=1 is the first cycle after it).
    function automatic exp_t model(input logic [15:0] m, input int dw, input bit cont, input int k);
        exp_t e;
        int   lst[$];
        int   n, p, s, off;
        e = '{idx: 0, idx_valid: 0, en: 1, strobe: 0, busy: 0, done: 0, frames: 0};
        for (int i = 0; i < 16; i++) if (!m[i]) lst.push_back(i);
        n = lst.size();
        if (n == 0) begin
            e.done = (k == 1);
            return e;
        end
        p   = BC + dw + 1;
        s   = (k - 1) / p;
        off = (k - 1) % p;
        if (!cont && s >= n) begin
            e.idx = lst[n-1]; e.idx_valid = 1;
            e.done = (s == n) && (off == 0);
            e.frames = 1;
            return e;
        end
        e.idx = lst[s % n]; e.idx_valid = 1; e.busy = 1;
        e.en = (off < BC); e.strobe = (off == BC);
        e.frames = s / n;
        return e;
    endfunction

    // Start a scan, check every cycle, optionally stop at cycle stop_at, always stop at the end.
    task automatic run_scan(input logic [15:0] m, input int dw, input bit cont, input int ncyc,
                            input int stop_at, input bit jitter);
        exp_t e;
        bit   stopped = 0;
        int   fstop = 0;
        @(negedge clk);
        skip_mask = m; dwell = DW'(dw); mode_cont = cont; start = 1'b1; stop = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            start = 1'b0; stop = 1'b0;
            e = model(m, dw, cont, k);
            if (stopped) begin
                chk("stopped_busy", busy, 0);
                chk("stopped_en", dec_enable, 1);
                chk("stopped_strobe", step_strobe, 0);
                chk("stopped_done", done, 0);
            end else begin
                if (e.idx_valid) chk("dec_in", dec_in, e.idx);
                chk("dec_enable", dec_enable, e.en);
                chk("step_strobe", step_strobe, e.strobe);
                chk("busy", busy, e.busy);
                chk("done", done, e.done);
`ifdef SCAN_FRAME_CNT_EN
                chk("frame_cnt", frame_cnt, (fc_base + e.frames) % 256);
`endif
            end
            if (!stopped && (k == ncyc || (k == stop_at && e.busy))) begin
                stop = 1'b1; stopped = 1; fstop = e.frames;
            end else if (jitter) begin
                if (e.busy && !stopped) start = 1'($urandom);
                skip_mask = 16'($urandom); dwell = DW'($urandom); mode_cont = 1'($urandom);
            end
        end
        @(negedge clk);
        stop = 1'b0; start = 1'b0;
        chk("end_idle", busy, 0);
        fc_base += fstop;
    endtask

    initial begin
        logic [15:0] m;
        int          dw, nc, sa;

        #12;
        chk("rst_dec_in", dec_in, 0);
        chk("rst_en", dec_enable, 1);
        chk("rst_busy", busy, 0);
        chk("rst_strobe", step_strobe, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_scan(16'h0000, 2, 0, 85, 0, 0);    // full pass, done at T+81
        run_scan(16'hFFFE, 0, 0, 6, 0, 0);     // single index, done at T+4
        run_scan(16'hFFFF, 3, 0, 4, 0, 0);     // nothing to scan
        run_scan(16'h7FFE, 1, 1, 24, 20, 0);   // 0,15,... stopped mid-drive
        run_scan(16'hFFDF, 1, 1, 30, 0, 1);    // lone index re-driven every period

        // start and stop together in IDLE: stop wins
        @(negedge clk);
        skip_mask = 16'h0000; start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        chk("startstop_busy", busy, 0);
        chk("startstop_done", done, 0);
        @(negedge clk);
        chk("startstop_busy2", busy, 0);

        for (int r = 0; r < 20; r++) begin
            m = 16'($urandom);
            if (r % 3 == 0) m = m | 16'($urandom);
            if (r % 5 == 0) m = ~(16'h1 << $urandom_range(15, 0));
            dw = $urandom_range(4, 0);
            nc = $urandom_range(120, 20);
            sa = ($urandom % 2) ? $urandom_range(nc, 1) : 0;
            run_scan(m, dw, 1'($urandom), nc, sa, 1);
        end

        // 256 wraps of a two-index continuous scan
        run_scan(16'hFFFC, 0, 1, 1540, 0, 0);

        // async reset in the drive of index 7
        @(negedge clk);
        skip_mask = 16'h0000; dwell = DW'(3); mode_cont = 1'b0; start = 1'b1;
        for (int k = 1; k <= 46; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("pre_rst_idx", dec_in, 7);
        chk("pre_rst_en", dec_enable, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_en", dec_enable, 1);
        chk("arst_dec_in", dec_in, 0);
        chk("arst_busy", busy, 0);
        chk("arst_strobe", step_strobe, 0);
`ifdef SCAN_FRAME_CNT_EN
        chk("arst_frame", frame_cnt, 0);
`endif
        fc_base = 0;
        @(negedge clk);
        rst_n = 1'b1;
        run_scan(16'hF0F0, 1, 0, 40, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
